// File: rtl/eth_gmii_rx_fcs_if.sv
// +-----------------------------------------------------------------------------+
// | Module   : eth_gmii_rx_fcs_if                                               |
// | Desc     : GMII/MII receive bus and 8-bit AXI4-Stream output (no tready).   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface eth_gmii_rx_fcs_if;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] output_axis_tdata;
  logic       output_axis_tvalid;
  logic       output_axis_tlast;
  logic       output_axis_tuser;

  // master is the PHY/sink side, slave is the receiver itself
  modport master (
    output gmii_rxd,
    output gmii_rx_dv,
    output gmii_rx_er,
    input  output_axis_tdata,
    input  output_axis_tvalid,
    input  output_axis_tlast,
    input  output_axis_tuser
  );

  modport slave (
    input  gmii_rxd,
    input  gmii_rx_dv,
    input  gmii_rx_er,
    output output_axis_tdata,
    output output_axis_tvalid,
    output output_axis_tlast,
    output output_axis_tuser
  );
endinterface

`default_nettype wire

// File: rtl/eth_gmii_rx_fcs.sv
// +-----------------------------------------------------------------------------+
// | Module   : eth_gmii_rx_fcs (with helper eth_lfsr)                           |
// | Desc     : GMII/MII frame receiver, preamble/SFD detect, CRC32 check, FCS   |
// |            strip, bad frames flagged on tuser.                              |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

// Galois LFSR step over DATA_WIDTH input bits; REVERSE=1 consumes data LSB first.
module eth_lfsr #(
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04C11DB7,
  parameter bit                    REVERSE    = 1'b1,
  parameter int                    DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] bit_reverse(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      r[i] = v[LFSR_WIDTH-1-i];
    end
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] c_poly_rev = bit_reverse(LFSR_POLY);

  always_comb begin
    logic                  fb;
    logic [LFSR_WIDTH-1:0] st;
    st = state_in;
    fb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        fb = st[0] ^ data_in[i];
        st = (st >> 1) ^ (fb ? c_poly_rev : '0);
      end else begin
        fb = st[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
        st = (st << 1) ^ (fb ? LFSR_POLY : '0);
      end
    end
    state_out = st;
  end

endmodule

module eth_gmii_rx_fcs #(
  parameter bit CHECK_RUNT       = 1'b0,
  parameter int MIN_FRAME_LENGTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  eth_gmii_rx_fcs_if.slave         bus,
  input  logic                     clk_enable,
  input  logic                     mii_select,
  output logic                     error_bad_frame,
  output logic                     error_bad_fcs,
  output logic [31:0]              fcs_reg
);

  localparam logic [31:0] c_crc_init    = 32'hFFFFFFFF;
  localparam logic [31:0] c_crc_residue = 32'hDEBB20E3;
  localparam logic [15:0] c_min_len     = 16'(MIN_FRAME_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PAYLOAD  = 2'd1,
    S_WAIT_END = 2'd2
  } state_t;

  state_t          r_state;
  logic [7:0]      r_rxd;
  logic            r_dv;
  logic            r_er;
  logic            r_phase;
  logic [3:0]      r_lo_nib;
  logic            r_lo_er;
  logic [31:0]     r_crc;
  logic [4:0][7:0] r_dly;
  logic [4:0]      r_dly_vld;
  logic [15:0]     r_cnt;
  logic            r_bad;
  logic [7:0]      r_tdata;
  logic            r_tvalid;
  logic            r_tlast;
  logic            r_tuser;
  logic            r_err_frame;
  logic            r_err_fcs;
  logic [31:0]     r_fcs;

  logic [7:0]      w_byte;
  logic            w_er;
  logic            w_strobe;
  logic [31:0]     w_crc_next;
  logic            w_crc_bad;
  logic            w_runt;

  // In MII mode the registered nibble is the high half; the low half was parked last enable
  assign w_byte     = mii_select ? {r_rxd[3:0], r_lo_nib} : r_rxd;
  assign w_er       = r_er | (mii_select & r_lo_er);
  assign w_strobe   = clk_enable & (~mii_select | ~r_dv | r_phase);
  assign w_crc_bad  = (r_crc != c_crc_residue);
  assign w_runt     = CHECK_RUNT && (r_cnt < c_min_len);

  eth_lfsr #(
    .LFSR_WIDTH (32),
    .LFSR_POLY  (32'h04C11DB7),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) u_crc (
    .data_in   (w_byte),
    .state_in  (r_crc),
    .state_out (w_crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rxd       <= 8'h00;
      r_dv        <= 1'b0;
      r_er        <= 1'b0;
      r_phase     <= 1'b0;
      r_lo_nib    <= 4'h0;
      r_lo_er     <= 1'b0;
      r_crc       <= c_crc_init;
      r_dly       <= '0;
      r_dly_vld   <= 5'b00000;
      r_cnt       <= 16'h0000;
      r_bad       <= 1'b0;
      r_tdata     <= 8'h00;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_err_frame <= 1'b0;
      r_err_fcs   <= 1'b0;
      r_fcs       <= 32'hFFFFFFFF;
    end else begin
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_err_frame <= 1'b0;
      r_err_fcs   <= 1'b0;

      if (clk_enable) begin
        r_rxd <= bus.gmii_rxd;
        r_dv  <= bus.gmii_rx_dv;
        r_er  <= bus.gmii_rx_er;
        if (!r_dv || !mii_select) begin
          r_phase <= 1'b0;
        end else if (!r_phase) begin
          r_phase  <= 1'b1;
          r_lo_nib <= r_rxd[3:0];
          r_lo_er  <= r_er;
        end else begin
          r_phase <= 1'b0;
        end
      end

      if (w_strobe) begin
        case (r_state)
          S_IDLE: begin
            if (r_dv) begin
              if (w_byte == 8'hD5) begin
                r_crc     <= c_crc_init;
                r_bad     <= 1'b0;
                r_cnt     <= 16'h0000;
                r_dly_vld <= 5'b00000;
                r_state   <= S_PAYLOAD;
              end else if (w_byte != 8'h55) begin
                r_state <= S_WAIT_END;
              end
            end
          end

          S_PAYLOAD: begin
            if (r_dv) begin
              r_crc     <= w_crc_next;
              r_dly     <= {r_dly[3:0], w_byte};
              r_dly_vld <= {r_dly_vld[3:0], 1'b1};
              if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
              end
              if (w_er) begin
                r_bad <= 1'b1;
              end
              if (r_dly_vld[4]) begin
                r_tdata  <= r_dly[4];
                r_tvalid <= 1'b1;
              end
            end else begin
              // Slots 3..0 now hold the FCS, slot 3 being its first byte on the wire
              r_state <= S_IDLE;
              if (r_dly_vld[4]) begin
                r_tdata     <= r_dly[4];
                r_tvalid    <= 1'b1;
                r_tlast     <= 1'b1;
                r_tuser     <= r_bad | w_crc_bad | w_runt;
                r_err_fcs   <= w_crc_bad;
                r_err_frame <= r_bad | w_runt;
                r_fcs       <= {r_dly[0], r_dly[1], r_dly[2], r_dly[3]};
              end else begin
                r_err_frame <= 1'b1;
              end
            end
          end

          S_WAIT_END: begin
            if (!r_dv) begin
              r_state <= S_IDLE;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.output_axis_tdata  = r_tdata;
  assign bus.output_axis_tvalid = r_tvalid;
  assign bus.output_axis_tlast  = r_tlast;
  assign bus.output_axis_tuser  = r_tuser;
  assign error_bad_frame        = r_err_frame;
  assign error_bad_fcs          = r_err_fcs;
  assign fcs_reg                = r_fcs;

endmodule

`default_nettype wire

// File: tb/tb_eth_gmii_rx_fcs.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_eth_gmii_rx_fcs                                               |
// | Desc     : Directed self-checking bench for eth_gmii_rx_fcs.                |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_eth_gmii_rx_fcs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        mii = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        dv = 1'b0;
  logic        er = 1'b0;

  wire         bf0, fcs0, bf1, fcs1;
  wire  [31:0] fcsreg0, fcsreg1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  eth_gmii_rx_fcs_if bus0();
  eth_gmii_rx_fcs_if bus1();

  assign bus0.gmii_rxd   = rxd;
  assign bus0.gmii_rx_dv = dv;
  assign bus0.gmii_rx_er = er;
  assign bus1.gmii_rxd   = rxd;
  assign bus1.gmii_rx_dv = dv;
  assign bus1.gmii_rx_er = er;

  eth_gmii_rx_fcs #(.CHECK_RUNT(1'b0), .MIN_FRAME_LENGTH(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .clk_enable(ce), .mii_select(mii),
    .error_bad_frame(bf0), .error_bad_fcs(fcs0), .fcs_reg(fcsreg0)
  );

  eth_gmii_rx_fcs #(.CHECK_RUNT(1'b1), .MIN_FRAME_LENGTH(64)) u_runt (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .clk_enable(ce), .mii_select(mii),
    .error_bad_frame(bf1), .error_bad_fcs(fcs1), .fcs_reg(fcsreg1)
  );

  // Output monitor: beats are {tlast, tuser, tdata}
  logic [9:0] beats[$];
  int n_bf0 = 0, n_fcs0 = 0, n_bf1 = 0, n_tuser1 = 0, ce_viol = 0;
  logic ce_q = 1'b1;

  always @(posedge clk) ce_q <= ce;

  always @(negedge clk) begin
    if (bus0.output_axis_tvalid) begin
      beats.push_back({bus0.output_axis_tlast, bus0.output_axis_tuser, bus0.output_axis_tdata});
      if (!ce_q) ce_viol++;
    end
    if (bf0) n_bf0++;
    if (fcs0) n_fcs0++;
    if (bf1) n_bf1++;
    if (bus1.output_axis_tvalid && bus1.output_axis_tlast && bus1.output_axis_tuser) n_tuser1++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0]  frm[$];
  logic [7:0]  pay[$];
  logic [31:0] exp_fcs;

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ d[b]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Payload bytes are 0,1,2,...; FCS covers the unflipped payload
  task automatic build_frame(input int n, input int flip);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    frm.delete();
    pay.delete();
    for (int k = 0; k < 7; k++) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < n; i++) begin
      b = 8'(i);
      c = crc_upd(c, b);
      if (i == flip) b = b ^ 8'h01;
      pay.push_back(b);
      frm.push_back(b);
    end
    exp_fcs = ~c;
    for (int k = 0; k < 4; k++) frm.push_back(exp_fcs[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_gmii(input int er_pos);
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      rxd = frm[i];
      dv  = 1'b1;
      er  = (i == er_pos);
    end
    @(negedge clk);
    rxd = 8'h00; dv = 1'b0; er = 1'b0;
    idle(10);
  endtask

  task automatic send_mii();
    logic [7:0] b;
    for (int i = 0; i < frm.size(); i++) begin
      b = frm[i];
      for (int h = 0; h < 2; h++) begin
        @(negedge clk); ce = 1'b0;
        @(negedge clk); ce = 1'b1; dv = 1'b1; er = 1'b0;
        rxd = (h == 0) ? {4'h0, b[3:0]} : {4'h0, b[7:4]};
      end
    end
    @(negedge clk); ce = 1'b0;
    @(negedge clk); ce = 1'b1; dv = 1'b0; rxd = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ce = ~ce;
    end
    ce = 1'b1;
    idle(4);
  endtask

  task automatic check_frame(input string tag, input int base, input int nexp, input logic tuser_exp);
    int       n_got, bad_data, bad_last;
    logic [9:0] e;
    n_got = beats.size() - base;
    bad_data = 0;
    bad_last = 0;
    chk({tag, "_beats"}, 32'(n_got), 32'(nexp));
    for (int i = 0; i < n_got; i++) begin
      e = beats[base + i];
      if (i >= pay.size() || e[7:0] !== pay[i]) bad_data++;
      if (e[9] !== (i == nexp - 1)) bad_last++;
    end
    chk({tag, "_data"}, 32'(bad_data), 32'd0);
    chk({tag, "_tlast"}, 32'(bad_last), 32'd0);
    if (n_got > 0) begin
      e = beats[beats.size() - 1];
      chk({tag, "_tuser"}, {31'd0, e[8]}, {31'd0, tuser_exp});
    end
  endtask

  initial begin
    int          base, b_bf0, b_fcs0, b_bf1, b_tu1;
    logic [31:0] fcs_good;

    // Reset values
    idle(3);
    chk("rst_outputs", {19'd0, bus0.output_axis_tvalid, bus0.output_axis_tlast,
                        bus0.output_axis_tuser, bf0, fcs0, bus0.output_axis_tdata}, 32'd0);
    chk("rst_fcs_reg", fcsreg0, 32'hFFFFFFFF);
    rst_n = 1'b1;
    idle(3);

    // Good GMII frame, 60 payload bytes (64 with FCS: exactly not a runt)
    build_frame(60, -1);
    fcs_good = exp_fcs;
    base = beats.size(); b_bf0 = n_bf0; b_fcs0 = n_fcs0; b_bf1 = n_bf1; b_tu1 = n_tuser1;
    send_gmii(-1);
    check_frame("good", base, 60, 1'b0);
    chk("good_bad_frame", 32'(n_bf0 - b_bf0), 32'd0);
    chk("good_bad_fcs", 32'(n_fcs0 - b_fcs0), 32'd0);
    chk("good_fcs_reg", fcsreg0, fcs_good);
    chk("good64_runt_tuser", 32'(n_tuser1 - b_tu1), 32'd0);
    chk("good64_runt_bf", 32'(n_bf1 - b_bf1), 32'd0);

    // Corrupted payload byte 10
    build_frame(60, 10);
    base = beats.size(); b_bf0 = n_bf0; b_fcs0 = n_fcs0;
    send_gmii(-1);
    check_frame("crcerr", base, 60, 1'b1);
    chk("crcerr_bad_fcs", 32'(n_fcs0 - b_fcs0), 32'd1);
    chk("crcerr_bad_frame", 32'(n_bf0 - b_bf0), 32'd0);

    // rx_er on payload byte 20
    build_frame(60, -1);
    base = beats.size(); b_bf0 = n_bf0; b_fcs0 = n_fcs0;
    send_gmii(8 + 20);
    check_frame("rxer", base, 60, 1'b1);
    chk("rxer_bad_frame", 32'(n_bf0 - b_bf0), 32'd1);
    chk("rxer_bad_fcs", 32'(n_fcs0 - b_fcs0), 32'd0);

    // MII mode with clk_enable toggling
    mii = 1'b1;
    build_frame(60, -1);
    base = beats.size(); b_bf0 = n_bf0; b_fcs0 = n_fcs0;
    send_mii();
    mii = 1'b0;
    check_frame("mii", base, 60, 1'b0);
    chk("mii_bad_frame", 32'(n_bf0 - b_bf0), 32'd0);
    chk("mii_bad_fcs", 32'(n_fcs0 - b_fcs0), 32'd0);
    chk("mii_ce_gate", 32'(ce_viol), 32'd0);
    chk("mii_fcs_reg", fcsreg0, fcs_good);

    // SFD followed by only 3 bytes
    build_frame(3, -1);
    for (int k = 0; k < 4; k++) void'(frm.pop_back());
    base = beats.size(); b_bf0 = n_bf0; b_fcs0 = n_fcs0;
    send_gmii(-1);
    chk("short_beats", 32'(beats.size() - base), 32'd0);
    chk("short_bad_frame", 32'(n_bf0 - b_bf0), 32'd1);
    chk("short_bad_fcs", 32'(n_fcs0 - b_fcs0), 32'd0);
    chk("short_fcs_reg", fcsreg0, fcs_good);

    // 40-byte valid frame: runt only when CHECK_RUNT=1
    build_frame(40, -1);
    base = beats.size(); b_bf0 = n_bf0; b_bf1 = n_bf1; b_tu1 = n_tuser1;
    send_gmii(-1);
    check_frame("f40", base, 40, 1'b0);
    chk("f40_bad_frame", 32'(n_bf0 - b_bf0), 32'd0);
    chk("f40_fcs_reg", fcsreg0, exp_fcs);
    chk("runt_tuser", 32'(n_tuser1 - b_tu1), 32'd1);
    chk("runt_bad_frame", 32'(n_bf1 - b_bf1), 32'd1);

    // Reset mid-payload, remainder ignored
    build_frame(60, -1);
    base = 0; b_bf0 = 0; b_fcs0 = 0;
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      rxd = frm[i]; dv = 1'b1; er = 1'b0;
      if (i == 40) begin
        @(posedge clk); #1;
        chk("prerst_tvalid", {31'd0, bus0.output_axis_tvalid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {19'd0, bus0.output_axis_tvalid, bus0.output_axis_tlast,
                               bus0.output_axis_tuser, bf0, fcs0, bus0.output_axis_tdata}, 32'd0);
        chk("midrst_fcs_reg", fcsreg0, 32'hFFFFFFFF);
      end
      if (i == 43) begin
        rst_n = 1'b1;
        base = beats.size(); b_bf0 = n_bf0; b_fcs0 = n_fcs0;
      end
    end
    @(negedge clk);
    rxd = 8'h00; dv = 1'b0;
    idle(10);
    chk("postrst_beats", 32'(beats.size() - base), 32'd0);
    chk("postrst_pulses", 32'((n_bf0 - b_bf0) + (n_fcs0 - b_fcs0)), 32'd0);

    build_frame(60, -1);
    base = beats.size(); b_bf0 = n_bf0; b_fcs0 = n_fcs0;
    send_gmii(-1);
    check_frame("recover", base, 60, 1'b0);
    chk("recover_pulses", 32'((n_bf0 - b_bf0) + (n_fcs0 - b_fcs0)), 32'd0);
    chk("recover_fcs_reg", fcsreg0, fcs_good);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
